mem_mp_rr: RTL

//  Parametrised successor of the single-channel valid/ready memory: NUM_PORTS independent

---
 rtl/mem_mp_pkg.sv | 17 +
 rtl/mem_mp_rr_arbiter.sv | 48 ++++
 rtl/mem_mp_rr.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_mp_pkg.sv
// Shared types and helpers for the multi-port round-robin memory.
package mem_mp_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_mp_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner, so port 0 wins first after reset.
module rr_arbiter
  import mem_mp_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_sel;
  logic          w_found;
  int            w_k;

  always_comb begin
    gnt     = '0;
    gnt_idx = r_ptr;
    w_found = 1'b0;
    w_k     = 0;
    w_sel   = '0;
    for (int i = 1; i <= N; i++) begin
      w_k = int'(r_ptr) + i;
      if (w_k >= N) w_k = w_k - N;
      w_sel = IW'(w_k);
      if (!w_found && req[w_sel]) begin
        w_found    = 1'b1;
        gnt_idx    = w_sel;
        gnt[w_sel] = 1'b1;
      end
    end
  end

  // Pointer only moves on an actual transfer, so an idle cycle keeps fairness state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IW'(N - 1);
    end else if (advance && w_found) begin
      r_ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/mem_mp_rr.sv
// NUM_PORTS valid/ready requesters sharing one single-port byte-enabled RAM via round-robin.
module mem_mp_rr
  import mem_mp_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = addr_w(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            valid_i,
  output logic [NUM_PORTS-1:0]            ready_o,
  input  logic [NUM_PORTS-1:0]            wr_rd_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_PORTS-1:0]            rd_valid_o,
  output logic [NUM_PORTS-1:0]            err_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = idx_w(NUM_PORTS);

  typedef struct packed {
    op_e                   wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         be;
  } req_t;

  req_t                  w_req_arr [NUM_PORTS];
  req_t                  w_req;
  logic [NUM_PORTS-1:0]  w_gnt;
  logic [IW-1:0]         w_gnt_idx;
  logic                  w_xfer;
  logic                  w_oor;

  logic [DATA_WIDTH-1:0] r_mem     [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_rd_valid;
  logic [NUM_PORTS-1:0]  r_err;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (valid_i),
    .advance (w_xfer),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Grants are suppressed while reset is held so nothing is accepted during reset.
  assign ready_o = w_gnt & {NUM_PORTS{rst}};
  assign w_xfer  = |ready_o;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_req_arr[p].wr_rd   = op_e'(wr_rd_i[p]);
      w_req_arr[p].addr    = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_req_arr[p].wr_data = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      w_req_arr[p].be      = be_i[p*NB +: NB];
    end
  end

  assign w_req = w_req_arr[w_gnt_idx];
  assign w_oor = (32'(w_req.addr) >= 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_xfer && !w_oor && (w_req.wr_rd == OP_WR)) begin
      for (int b = 0; b < NB; b++) begin
        if (w_req.be[b]) r_mem[w_req.addr][b*8 +: 8] <= w_req.wr_data[b*8 +: 8];
      end
    end
  end

  // Response stage: read data lands in the granted port's holding register one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= '0;
      r_err      <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_rd_data[p] <= '0;
    end else begin
      r_rd_valid <= '0;
      r_err      <= '0;
      if (w_xfer) begin
        if (w_oor) begin
          r_err[w_gnt_idx] <= 1'b1;
        end else if (w_req.wr_rd == OP_RD) begin
          r_rd_valid[w_gnt_idx] <= 1'b1;
          r_rd_data[w_gnt_idx]  <= r_mem[w_req.addr];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = r_rd_data[p];
  end

  assign rd_valid_o = r_rd_valid;
  assign err_o      = r_err;

endmodule
